wb_seg_reg_cached: RTL
======================

Name: wb_seg_reg_cached

Overview:
- Parametrised MEM/WB segment register with a handshake-aware data-cache front end.
- Drives the data cache from MEM-stage signals and raises stall_mem while the cache reports a miss.
- Holds load data stable across pipeline stalls and registers MEM results into the WB stage.
- Keeps per-access read/write hit/miss and miss-cycle counters, selectable for CSR readout.

Parameters:
XLEN, 32, data/address width; must be a multiple of 8
RD_W, 5, destination register index width
RW_W, 3, RegWrite encoding width
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
en  in  1  pipeline advance from hazard unit; 0 = hold WB regs
clear  in  1  flush WB regs (effective only when en=1)
stall_mem  out  1  cache busy; hazard unit must deassert en
addr_m  in  XLEN  data address
wdata_m  in  XLEN  store data
we_m  in  XLEN/8  store byte enables
mem_to_reg_m  in  1  load in MEM
result_m  in  XLEN  ALU result
rd_m  in  RD_W  destination register
regwrite_m  in  RW_W  RegWrite code
cache_addr  out  XLEN  equals addr_m
cache_wdata  out  XLEN  equals wdata_m
cache_be  out  XLEN/8  equals we_m
cache_rd_req  out  1  equals mem_to_reg_m
cache_wr_req  out  1  OR-reduction of we_m
cache_miss  in  1  combinational miss/busy from cache
cache_rdata  in  XLEN  combinational read data
rdata_w  out  XLEN  load data for WB
byte_off_w  out  log2(XLEN/8)  registered addr_m low bits
result_w  out  XLEN  registered result_m
rd_w  out  RD_W  registered rd_m
regwrite_w  out  RW_W  registered regwrite_m
mem_to_reg_w  out  1  registered mem_to_reg_m
cnt_sel  in  3  0 rd_hit, 1 rd_miss, 2 wr_hit, 3 wr_miss, 4 miss_cycles, 5-7 read 0
cnt_clr  in  1  synchronous clear of all counters
cnt_rdata  out  CNT_W  selected counter (combinational mux)

Behaviour:
- Reset: all WB regs, byte_off_w, counters and internal flags = 0; rdata_w = cache_rdata.
- access = cache_rd_req | cache_wr_req; stall_mem = access & cache_miss (combinational, no latency).
- WB regs, posedge clk:
  - en=1, clear=0: load from MEM inputs; byte_off_w <= addr_m[low bits].
  - en=1, clear=1: all WB regs = 0.
  - en=0: hold.
- Load hold:
  - Internal hold_flag/hold_data; rdata_w = hold_flag ? hold_data : cache_rdata.
  - On a cycle with en=0 and hold_flag=0: hold_flag<=1, hold_data<=rdata_w.
  - Further en=0 cycles: keep hold_data unchanged (captured once).
  - en=1: hold_flag<=0.
- Access accounting, internal flags saw_miss and counted:
  - access & cache_miss: saw_miss<=1; miss_cycles +1.
  - Completion = access & ~cache_miss & ~counted. On completion, increment exactly one of:
    - rd_hit: rd_req and saw_miss=0
    - rd_miss: rd_req and saw_miss=1
    - wr_hit: wr_req only and saw_miss=0
    - wr_miss: wr_req only and saw_miss=1
    - rd_req has priority if both requests are asserted.
  - Completion with en=0: counted<=1 (the same access is not recounted while stalled).
  - en=1: counted<=0 and saw_miss<=0 (the next MEM instruction is a new access, even to the same address).
  - Completion with en=1: count, then clear both flags.
- Counters saturate at all-ones and never wrap. cnt_clr has priority over increment in the same cycle.
- Reset mid-miss: flags and counters zero immediately; stall_mem follows the inputs combinationally.

Test Plan:
1. Load hit: rd_req=1, cache_miss=0, en=1, cache_rdata=0xDEADBEEF, addr_m=0x102 -> stall_mem=0; next cycle byte_off_w=2; rd_hit=1, others 0.
2. Load miss for 3 cycles, en driven from ~stall_mem -> stall_mem high 3 cycles; miss_cycles=3; rd_miss=1; rd_hit=0.
3. Two consecutive stores to 0x40, both hits -> wr_hit=2. Same address is still counted twice.
4. Load completes, then en=0 for 4 cycles (external hazard) while cache_rdata changes to 0x0 -> rdata_w stays 0xDEADBEEF; rd_hit=1, not 5.
5. clear=1, en=1 with regwrite_m=3, rd_m=7 -> regwrite_w=0, rd_w=0; clear=1, en=0 -> WB regs hold.
6. CNT_W=4, 20 load hits -> rd_hit=15 (saturated). Then cnt_clr=1 during a hit -> all counters 0. Then rst asserted mid-miss -> counters 0 asynchronously.

Source files
------------

// File: rtl/wb_seg_reg_cached.sv
// MEM/WB segment register with a data-cache front end, load-data hold
// across stalls and per-access hit/miss performance counters.
module wb_seg_reg_cached #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int RW_W  = 3,
  parameter int CNT_W = 32,
  localparam int BE_W  = XLEN / 8,
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  output logic             stall_mem,
  input  logic [XLEN-1:0]  addr_m,
  input  logic [XLEN-1:0]  wdata_m,
  input  logic [BE_W-1:0]  we_m,
  input  logic             mem_to_reg_m,
  input  logic [XLEN-1:0]  result_m,
  input  logic [RD_W-1:0]  rd_m,
  input  logic [RW_W-1:0]  regwrite_m,
  output logic [XLEN-1:0]  cache_addr,
  output logic [XLEN-1:0]  cache_wdata,
  output logic [BE_W-1:0]  cache_be,
  output logic             cache_rd_req,
  output logic             cache_wr_req,
  input  logic             cache_miss,
  input  logic [XLEN-1:0]  cache_rdata,
  output logic [XLEN-1:0]  rdata_w,
  output logic [OFF_W-1:0] byte_off_w,
  output logic [XLEN-1:0]  result_w,
  output logic [RD_W-1:0]  rd_w,
  output logic [RW_W-1:0]  regwrite_w,
  output logic             mem_to_reg_w,
  input  logic [2:0]       cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_rdata
);

  logic            access;
  logic            complete;
  logic            hold_flag;
  logic [XLEN-1:0] hold_data;
  logic            saw_miss;
  logic            counted;
  logic [4:0]      inc;
  logic [CNT_W-1:0] cnt_q [5];

  assign cache_addr   = addr_m;
  assign cache_wdata  = wdata_m;
  assign cache_be     = we_m;
  assign cache_rd_req = mem_to_reg_m;
  assign cache_wr_req = |we_m;

  assign access    = cache_rd_req | cache_wr_req;
  assign stall_mem = access & cache_miss;
  assign complete  = access & ~cache_miss & ~counted;
  assign rdata_w   = hold_flag ? hold_data : cache_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_off_w   <= '0;
      result_w     <= '0;
      rd_w         <= '0;
      regwrite_w   <= '0;
      mem_to_reg_w <= 1'b0;
    end else if (en) begin
      if (clear) begin
        byte_off_w   <= '0;
        result_w     <= '0;
        rd_w         <= '0;
        regwrite_w   <= '0;
        mem_to_reg_w <= 1'b0;
      end else begin
        byte_off_w   <= addr_m[OFF_W-1:0];
        result_w     <= result_m;
        rd_w         <= rd_m;
        regwrite_w   <= regwrite_m;
        mem_to_reg_w <= mem_to_reg_m;
      end
    end
  end

  // Capture once on the first stalled edge so later cache changes are hidden
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_flag <= 1'b0;
      hold_data <= '0;
    end else if (en) begin
      hold_flag <= 1'b0;
    end else if (!hold_flag) begin
      hold_flag <= 1'b1;
      hold_data <= rdata_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saw_miss <= 1'b0;
      counted  <= 1'b0;
    end else if (en) begin
      saw_miss <= 1'b0;
      counted  <= 1'b0;
    end else begin
      if (stall_mem) saw_miss <= 1'b1;
      if (complete)  counted  <= 1'b1;
    end
  end

  always_comb begin
    inc    = '0;
    inc[4] = stall_mem;
    if (complete) begin
      unique case (1'b1)
        cache_rd_req & ~saw_miss: inc[0] = 1'b1;
        cache_rd_req &  saw_miss: inc[1] = 1'b1;
        ~cache_rd_req & ~saw_miss: inc[2] = 1'b1;
        default:                  inc[3] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (cnt_clr)
          cnt_q[i] <= '0;
        else if (inc[i] && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_rdata = '0;
    case (cnt_sel)
      3'd0:    cnt_rdata = cnt_q[0];
      3'd1:    cnt_rdata = cnt_q[1];
      3'd2:    cnt_rdata = cnt_q[2];
      3'd3:    cnt_rdata = cnt_q[3];
      3'd4:    cnt_rdata = cnt_q[4];
      default: cnt_rdata = '0;
    endcase
  end

endmodule
